// File: rtl/mult_booth_ctrl.sv
// Radix-2 Booth multiplier sequencer: operand handshake, datapath
// clear/load, N add/sub + shift iterations, held result-valid until ack.

package mult_booth_pkg;

    typedef struct packed {
        logic load_A;
        logic load_B;
        logic load_add;
        logic shift_HQ_LQ_Q_1;
        logic add_sub;
    } mult_control_t;

endpackage

module mult_booth_ctrl
    import mult_booth_pkg::*;
#(
    parameter int N = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [N-1:0]  A_in,
    input  logic [N-1:0]  B_in,
    output logic          ready,
    output logic [N-1:0]  A,
    output logic [N-1:0]  B,
    output logic          dp_clr,
    output mult_control_t mult_control,
    input  logic [1:0]    Q_LSB,
    output logic          valid,
    input  logic          ack
);

    localparam int CW = $clog2(N) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_EVAL,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [N-1:0]    r_a;
    logic [N-1:0]    r_b;
    logic            w_last;
    mult_control_t   w_ctl;

    // The shift being issued now is the final iteration
    assign w_last = (r_cnt == CW'(N - 1));

    // Sequencer state, iteration count and captured operands
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= A_in;
                        r_b     <= B_in;
                        r_state <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    r_state <= S_LOAD;
                end
                S_LOAD: begin
                    r_cnt   <= '0;
                    r_state <= S_EVAL;
                end
                S_EVAL: begin
                    r_state <= S_SHIFT;
                end
                S_SHIFT: begin
                    r_cnt   <= r_cnt + 1'b1;
                    r_state <= w_last ? S_DONE : S_EVAL;
                end
                S_DONE: begin
                    if (ack) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Datapath command decode; EVAL follows the live Booth bit pair
    always_comb begin
        w_ctl = '0;
        unique case (r_state)
            S_LOAD: begin
                w_ctl.load_A = 1'b1;
                w_ctl.load_B = 1'b1;
            end
            S_EVAL: begin
                unique case (Q_LSB)
                    2'b01: begin
                        w_ctl.load_add = 1'b1;
                        w_ctl.add_sub  = 1'b1;
                    end
                    2'b10: begin
                        w_ctl.load_add = 1'b1;
                    end
                    default: begin
                        w_ctl.load_add = 1'b0;
                    end
                endcase
            end
            S_SHIFT: begin
                w_ctl.shift_HQ_LQ_Q_1 = 1'b1;
            end
            default: begin
                w_ctl = '0;
            end
        endcase
    end

    assign mult_control = w_ctl;
    assign A            = r_a;
    assign B            = r_b;
    assign ready        = (r_state == S_IDLE);
    assign valid        = (r_state == S_DONE);
    assign dp_clr       = ~rst | (r_state == S_CLEAR);

endmodule

// File: tb/tb_mult_booth_ctrl.sv
// Directed bench for mult_booth_ctrl with a behavioural Booth datapath
// and a cycle-by-cycle command/handshake monitor.

module tb_mult_booth_ctrl;
    import mult_booth_pkg::*;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [N-1:0]  A_in;
    logic [N-1:0]  B_in;
    logic          ready;
    logic [N-1:0]  A;
    logic [N-1:0]  B;
    logic          dp_clr;
    mult_control_t mult_control;
    logic [1:0]    Q_LSB;
    logic          valid;
    logic          ack;

    int n_vec = 0;
    int n_err = 0;

    mult_booth_ctrl #(.N(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .A_in         (A_in),
        .B_in         (B_in),
        .ready        (ready),
        .A            (A),
        .B            (B),
        .dp_clr       (dp_clr),
        .mult_control (mult_control),
        .Q_LSB        (Q_LSB),
        .valid        (valid),
        .ack          (ack)
    );

    always #5 clk = ~clk;

    // Booth datapath with one guard bit in HQ
    logic [N:0]   hq = '0;
    logic [N-1:0] lq = '0;
    logic [N-1:0] m  = '0;
    logic         q1 = 1'b0;
    logic [2*N-1:0] Y;

    assign Y     = {hq[N-1:0], lq};
    assign Q_LSB = {lq[0], q1};

    always @(posedge clk) begin
        if (dp_clr) begin
            hq <= '0;
            lq <= '0;
            m  <= '0;
            q1 <= 1'b0;
        end else begin
            if (mult_control.load_A) m <= A;
            if (mult_control.load_B) lq <= B;
            if (mult_control.load_add)
                hq <= mult_control.add_sub ? hq + {m[N-1], m}
                                           : hq - {m[N-1], m};
            if (mult_control.shift_HQ_LQ_Q_1)
                {hq, lq, q1} <= {hq[N], hq, lq};
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Phase tracker: cycles since the accepting edge
    logic busy = 1'b0;
    int   since = 0;
    logic mon_en = 1'b0;

    always @(posedge clk) begin
        if (!rst) begin
            busy <= 1'b0;
        end else if (!busy) begin
            if (start) begin
                busy  <= 1'b1;
                since <= 0;
            end
        end else if (since == 2*N+2) begin
            if (ack) busy <= 1'b0;
        end else begin
            since <= since + 1;
        end
    end

    // Per-cycle expectation of handshake and command outputs
    always @(negedge clk) begin
        logic e_eval, e_add;
        logic [7:0] e, g;
        if (mon_en) begin
            e_eval = busy && since >= 2 && since <= 2*N && (since % 2 == 0);
            e_add  = e_eval && (Q_LSB == 2'b01 || Q_LSB == 2'b10);
            e = {!busy,
                 busy && since == 2*N+2,
                 !rst || (busy && since == 0),
                 busy && since == 1,
                 busy && since == 1,
                 e_add,
                 busy && since >= 3 && since <= 2*N+1 && (since % 2 == 1),
                 e_add && Q_LSB == 2'b01};
            g = {ready, valid, dp_clr, mult_control};
            chk("mon_ctl", g, e);
            chk("mon_excl", mult_control.load_add
                            & mult_control.shift_HQ_LQ_Q_1, 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [2*N-1:0] y, input string tag);
        int n;
        chk({tag, "_rdy"}, ready, 1);
        A_in  = a;
        B_in  = b;
        ack   = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        A_in  = ~a;
        B_in  = ~b;
        chk({tag, "_A"}, A, a);
        chk({tag, "_B"}, B, b);
        n = 0;
        while (!valid && n < 30) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, n, 2*N+2);
        chk({tag, "_Y"}, Y, y);
        tick();
        chk({tag, "_rdy2"}, {ready, valid}, 2'b10);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [2*N-1:0] yh;
        int n;
        rst   = 1'b0;
        start = 1'b0;
        ack   = 1'b0;
        A_in  = '0;
        B_in  = '0;
        tick();
        tick();
        mon_en = 1'b1;
        chk("rst_hs", {ready, valid, dp_clr}, 3'b101);
        chk("rst_ctl", mult_control, 0);
        chk("rst_AB", {A, B}, 0);
        rst = 1'b1;
        tick();
        chk("rst_rel_clr", dp_clr, 0);

        run(4'd3, 4'd2, 8'h06, "p3x2");
        run(4'hD, 4'd2, 8'hFA, "m3x2");
        run(4'h8, 4'h8, 8'h40, "m8xm8");
        run(4'd7, 4'h8, 8'hC8, "p7xm8");

        // hold with ack low
        A_in  = 4'd3;
        B_in  = 4'd2;
        ack   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!valid && n < 30) begin
            tick();
            n++;
        end
        chk("hold_lat", n, 2*N+2);
        yh = Y;
        chk("hold_Y0", yh, 8'h06);
        for (int i = 0; i < 20; i++) begin
            if (i == 7) begin
                start = 1'b1;
                A_in  = 4'd5;
            end
            if (i == 8) start = 1'b0;
            tick();
            chk("hold_valid", valid, 1);
            chk("hold_Y", Y, yh);
            chk("hold_ctl", mult_control, 0);
            if (i == 7) chk("hold_rdy", ready, 0);
        end
        ack   = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ack_idle", {ready, valid, dp_clr}, 3'b100);
        tick();
        chk("ack_nostart", ready, 1);

        // back-to-back with operand changes after accept
        run(4'd5, 4'd5, 8'h19, "p5x5");
        run(4'd0, 4'hF, 8'h00, "p0xm1");

        // reset mid-run
        A_in  = 4'd7;
        B_in  = 4'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        chk("mid_busy", ready, 0);
        rst = 1'b0;
        tick();
        chk("mid_hs", {ready, valid, dp_clr}, 3'b101);
        chk("mid_ctl", mult_control, 0);
        rst = 1'b1;
        tick();
        run(4'd2, 4'd3, 8'h06, "p2x3");

        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
